// File: rtl/seg_scan_capture.sv
// Capture side of a 4-digit multiplexed 7-segment display. It samples the scanned segment and
// digit lines, waits for each dwell to settle, decodes it and assembles complete 4-digit frames.
module seg_scan_capture #(
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 16384,
    parameter int unsigned CNT_W   = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  seg_in,
    input  logic [3:0]  way_in,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [3:0]  blank,
    output logic [3:0]  glyph_err,
    output logic        frame_stb,
    output logic        frame_valid,
    output logic        scan_err
);

    localparam int unsigned SEG_W = 8;
    localparam int unsigned WAY_W = 4;
    localparam int unsigned NIB_W = 4;
    localparam int unsigned DW_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [DW_W-1:0]  DW_LAST = DW_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic [SEG_W-1:0] r_seg, p_seg;
    logic [WAY_W-1:0] r_way, p_way;
    logic [DW_W-1:0]  dwell;
    logic             armed;
    logic [WAY_W-1:0] mask;
    logic [CNT_W-1:0] to_cnt;

    logic             chg_c, one_c, multi_c, armed_n_c, cap_c, to_fire_c;
    logic [DW_W-1:0]  dwell_n_c;
    logic [1:0]       cap_idx_c;
    logic [WAY_W-1:0] mask_n_c;
    logic [NIB_W-1:0] dec_val_c;
    logic             dec_ok_c, dec_blank_c;

    // Dwell tracking: a held one-hot (way,seg) pair is captured once, after SETTLE cycles.
    always_comb begin
        chg_c     = {r_way, r_seg} != {p_way, p_seg};
        one_c     = $onehot(r_way);
        multi_c   = $countones(r_way) > 1;
        dwell_n_c = dwell;
        if (chg_c || !one_c) begin
            dwell_n_c = '0;
        end else if (dwell != DW_LAST) begin
            dwell_n_c = dwell + DW_W'(1);
        end
        armed_n_c = armed | chg_c;
        cap_c     = one_c && armed_n_c && (dwell_n_c == DW_LAST);
        to_fire_c = !cap_c && (to_cnt == TO_LAST);
    end

    always_comb begin
        cap_idx_c = 2'd0;
        for (int k = 0; k < int'(WAY_W); k++) begin
            if (r_way[k]) cap_idx_c = 2'(k);
        end
        mask_n_c = mask | (4'b0001 << cap_idx_c);
    end

    // Glyph decode of a..g; 0011111 is read as b rather than the alternate 6.
    always_comb begin
        dec_ok_c    = 1'b1;
        dec_val_c   = 4'h0;
        dec_blank_c = (r_seg[7:1] == 7'b0000000);
        case (r_seg[7:1])
            7'b1111110: dec_val_c = 4'h0;
            7'b0110000: dec_val_c = 4'h1;
            7'b1101101: dec_val_c = 4'h2;
            7'b1111001: dec_val_c = 4'h3;
            7'b0110011: dec_val_c = 4'h4;
            7'b1011011: dec_val_c = 4'h5;
            7'b1011111: dec_val_c = 4'h6;
            7'b1110000: dec_val_c = 4'h7;
            7'b1110010: dec_val_c = 4'h7;
            7'b1111111: dec_val_c = 4'h8;
            7'b1111011: dec_val_c = 4'h9;
            7'b1110011: dec_val_c = 4'h9;
            7'b1110111: dec_val_c = 4'hA;
            7'b0011111: dec_val_c = 4'hB;
            7'b1001110: dec_val_c = 4'hC;
            7'b0111101: dec_val_c = 4'hD;
            7'b1001111: dec_val_c = 4'hE;
            7'b1000111: dec_val_c = 4'hF;
            default:    dec_ok_c  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg       <= '0;
            r_way       <= '0;
            p_seg       <= '0;
            p_way       <= '0;
            dwell       <= '0;
            armed       <= 1'b0;
            mask        <= '0;
            to_cnt      <= '0;
            digits      <= '0;
            dp          <= '0;
            blank       <= '0;
            glyph_err   <= '0;
            frame_stb   <= 1'b0;
            frame_valid <= 1'b0;
            scan_err    <= 1'b0;
        end else begin
            r_seg     <= seg_in;
            r_way     <= way_in;
            p_seg     <= r_seg;
            p_way     <= r_way;
            dwell     <= dwell_n_c;
            armed     <= armed_n_c & ~cap_c;
            scan_err  <= multi_c;
            frame_stb <= 1'b0;

            if (cap_c) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + CNT_W'(1);
            end

            if (cap_c) begin
                dp[cap_idx_c] <= r_seg[0];
                if (dec_blank_c) begin
                    digits[{cap_idx_c, 2'b00} +: NIB_W] <= '0;
                    blank[cap_idx_c]                    <= 1'b1;
                    glyph_err[cap_idx_c]                <= 1'b0;
                end else if (dec_ok_c) begin
                    digits[{cap_idx_c, 2'b00} +: NIB_W] <= dec_val_c;
                    blank[cap_idx_c]                    <= 1'b0;
                    glyph_err[cap_idx_c]                <= 1'b0;
                end else begin
                    blank[cap_idx_c]                    <= 1'b0;
                    glyph_err[cap_idx_c]                <= 1'b1;
                end
                if (mask_n_c == 4'b1111) begin
                    mask        <= '0;
                    frame_stb   <= 1'b1;
                    frame_valid <= 1'b1;
                end else begin
                    mask <= mask_n_c;
                end
            end else if (to_fire_c) begin
                // Scan stalled: drop validity and the partial frame, keep the last values.
                frame_valid <= 1'b0;
                mask        <= '0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: a table of held (way,seg) dwells with expected outputs,
// followed by hand-written sequences for settling, scan errors, timeout and mid-dwell reset.
module tb_seg_scan_capture;

    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 16384;
    localparam int unsigned CNT_W   = 15;
    localparam int          LAT     = SETTLE + 1;
    localparam int          NV      = 17;

    logic        clk;
    logic        rst_n;
    logic [7:0]  seg_in;
    logic [3:0]  way_in;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  glyph_err;
    logic        frame_stb;
    logic        frame_valid;
    logic        scan_err;

    seg_scan_capture #(
        .SETTLE (SETTLE),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .way_in     (way_in),
        .digits     (digits),
        .dp         (dp),
        .blank      (blank),
        .glyph_err  (glyph_err),
        .frame_stb  (frame_stb),
        .frame_valid(frame_valid),
        .scan_err   (scan_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  way;
        logic [7:0]  seg;
        logic [15:0] dig;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  gerr;
        logic        fv;
        int          stb;
    } vec_t;

    vec_t vecs [NV];

    int n_tests = 0;
    int n_fail  = 0;
    int stb_total  = 0;
    int serr_total = 0;
    int s0, e0, k, bad;
    logic found;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_stb) stb_total <= stb_total + 1;
        if (scan_err)  serr_total <= serr_total + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " digits"},      32'(digits),      32'h0);
        chk({tag, " dp"},          32'(dp),          32'h0);
        chk({tag, " blank"},       32'(blank),       32'h0);
        chk({tag, " glyph_err"},   32'(glyph_err),   32'h0);
        chk({tag, " frame_stb"},   32'(frame_stb),   32'h0);
        chk({tag, " frame_valid"}, 32'(frame_valid), 32'h0);
        chk({tag, " scan_err"},    32'(scan_err),    32'h0);
    endtask

    task automatic hold(input logic [3:0] w, input logic [7:0] s, input int n);
        way_in = w;
        seg_in = s;
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        //          way      seg    digits    dp       blank    gerr     fv  stb
        vecs[0]  = '{4'b1000, 8'hDA, 16'h2000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0};
        vecs[1]  = '{4'b0100, 8'hFE, 16'h2800, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0};
        vecs[2]  = '{4'b0010, 8'hE7, 16'h2890, 4'b0010, 4'b0000, 4'b0000, 1'b0, 0};
        vecs[3]  = '{4'b0001, 8'h61, 16'h2891, 4'b0011, 4'b0000, 4'b0000, 1'b1, 1};
        vecs[4]  = '{4'b1000, 8'hEE, 16'hA891, 4'b0011, 4'b0000, 4'b0000, 1'b1, 0};
        vecs[5]  = '{4'b0100, 8'h3F, 16'hAB91, 4'b0111, 4'b0000, 4'b0000, 1'b1, 0};
        vecs[6]  = '{4'b0001, 8'h00, 16'hAB90, 4'b0110, 4'b0001, 4'b0000, 1'b1, 0};
        vecs[7]  = '{4'b0010, 8'hE4, 16'hAB70, 4'b0100, 4'b0001, 4'b0000, 1'b1, 1};
        vecs[8]  = '{4'b0010, 8'h92, 16'hAB70, 4'b0100, 4'b0001, 4'b0010, 1'b1, 0};
        vecs[9]  = '{4'b1000, 8'h9D, 16'hCB70, 4'b1100, 4'b0001, 4'b0010, 1'b1, 0};
        vecs[10] = '{4'b0100, 8'h7A, 16'hCD70, 4'b1000, 4'b0001, 4'b0010, 1'b1, 0};
        vecs[11] = '{4'b0001, 8'h9E, 16'hCD7E, 4'b1000, 4'b0000, 4'b0010, 1'b1, 1};
        vecs[12] = '{4'b0001, 8'hFD, 16'hCD70, 4'b1001, 4'b0000, 4'b0010, 1'b1, 0};
        vecs[13] = '{4'b0000, 8'hFF, 16'hCD70, 4'b1001, 4'b0000, 4'b0010, 1'b1, 0};
        vecs[14] = '{4'b0010, 8'hF2, 16'hCD30, 4'b1001, 4'b0000, 4'b0000, 1'b1, 0};
        vecs[15] = '{4'b0100, 8'h66, 16'hC430, 4'b1001, 4'b0000, 4'b0000, 1'b1, 0};
        vecs[16] = '{4'b1000, 8'hB6, 16'h5430, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1};

        rst_n  = 1'b0;
        way_in = 4'b0000;
        seg_in = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            s0 = stb_total;
            e0 = serr_total;
            hold(vecs[i].way, vecs[i].seg, 8);
            chk($sformatf("v%0d digits", i),      32'(digits),          32'(vecs[i].dig));
            chk($sformatf("v%0d dp", i),          32'(dp),              32'(vecs[i].dp));
            chk($sformatf("v%0d blank", i),       32'(blank),           32'(vecs[i].blank));
            chk($sformatf("v%0d glyph_err", i),   32'(glyph_err),       32'(vecs[i].gerr));
            chk($sformatf("v%0d frame_valid", i), 32'(frame_valid),     32'(vecs[i].fv));
            chk($sformatf("v%0d frame_stb", i),   32'(stb_total - s0),  32'(vecs[i].stb));
            chk($sformatf("v%0d scan_err", i),    32'(serr_total - e0), 32'h0);
        end

        // Long hold captures once; a short glitch never lands, the restored glyph recaptures.
        hold(4'b1000, 8'hDA, 8);
        hold(4'b0100, 8'hFE, 8);
        hold(4'b0010, 8'hE7, 8);
        s0 = stb_total;
        hold(4'b0001, 8'h61, 100);
        chk("hold frame_stb", 32'(stb_total - s0), 32'd1);
        chk("hold digits",    32'(digits),         32'h2891);
        chk("hold dp",        32'(dp),             32'b0011);
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            hold(4'b0001, (c < 2) ? 8'hFC : 8'h61, 1);
            if (digits[3:0] != 4'h1 || dp[0] != 1'b1) bad++;
        end
        chk("glitch bad cycles", 32'(bad), 32'd0);
        s0 = stb_total;
        hold(4'b1000, 8'hDA, 8);
        hold(4'b0100, 8'hFE, 8);
        chk("recapture partial stb", 32'(stb_total - s0), 32'd0);
        hold(4'b0010, 8'hE7, 8);
        chk("recapture frame stb",   32'(stb_total - s0), 32'd1);

        // Multi-hot select: scan_err per cycle, nothing captured.
        e0 = serr_total;
        s0 = stb_total;
        hold(4'b0110, 8'hFE, 3);
        hold(4'b0000, 8'hFE, 5);
        chk("scan_err cycles", 32'(serr_total - e0), 32'd3);
        chk("scan_err digits", 32'(digits),          32'h2891);
        hold(4'b1000, 8'hDA, 8);
        hold(4'b0100, 8'hFE, 8);
        hold(4'b0001, 8'h61, 8);
        chk("after err partial stb", 32'(stb_total - s0), 32'd0);

        way_in = 4'b0010;
        seg_in = 8'hE7;
        k = 0;
        found = 1'b0;
        while (!found && k < 20) begin
            @(posedge clk);
            #1;
            k++;
            found = frame_stb;
        end
        chk("last digit latency", 32'(k),           32'(LAT));
        chk("last digit valid",   32'(frame_valid), 32'd1);

        // Stop scanning; validity must drop exactly TIMEOUT edges after the last capture.
        way_in = 4'b0000;
        k = 0;
        while (frame_valid && k < int'(TIMEOUT) + 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("timeout edges",     32'(k),         32'(TIMEOUT));
        chk("timeout digits",    32'(digits),    32'h2891);
        chk("timeout dp",        32'(dp),        32'b0011);
        chk("timeout glyph_err", 32'(glyph_err), 32'h0);

        // Reset in the middle of a dwell, then settle latency from release.
        @(negedge clk);
        way_in = 4'b0100;
        seg_in = 8'hFE;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("mid reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        found = 1'b0;
        while (!found && k < 20) begin
            @(posedge clk);
            #1;
            k++;
            found = (digits == 16'h0800);
        end
        chk("post reset latency", 32'(k), 32'(LAT));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
